// File: rtl/lc3_control_unit_if.sv
// Control-unit <-> datapath/memory bundle: status inputs in, control word and memory request out.
// master = control sequencer, slave = datapath / memory side.
interface lc3_control_unit_if #(
  parameter int STATE_W = 5
);
  logic               run;
  logic [15:0]        ir;
  logic               n;
  logic               z;
  logic               p;
  logic               mem_r;

  logic               ld_mar;
  logic               ld_mdr;
  logic               ld_ir;
  logic               ld_pc;
  logic               ld_reg;
  logic               ld_cc;
  logic               gate_pc;
  logic               gate_mdr;
  logic               gate_alu;
  logic               gate_marmux;
  logic [1:0]         pcmux;
  logic               addr1mux;
  logic [1:0]         addr2mux;
  logic               marmux;
  logic [1:0]         sr1mux;
  logic [1:0]         drmux;
  logic [1:0]         aluk;
  logic               mio_en;
  logic               r_w;
  logic               halted;
  logic               mem_err;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  run, ir, n, z, p, mem_r,
    output ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
           gate_pc, gate_mdr, gate_alu, gate_marmux,
           pcmux, addr1mux, addr2mux, marmux, sr1mux, drmux, aluk,
           mio_en, r_w, halted, mem_err, state_o
  );

  modport slave (
    output run, ir, n, z, p, mem_r,
    input  ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc,
           gate_pc, gate_mdr, gate_alu, gate_marmux,
           pcmux, addr1mux, addr2mux, marmux, sr1mux, drmux, aluk,
           mio_en, r_w, halted, mem_err, state_o
  );
endinterface

// File: rtl/lc3_control_unit.sv
// Moore LC-3 sequencer (ADD/AND/NOT/BR/JMP/LD/ST/LDR/STR); fetch+decode 4 cycles, ALU/BR/JMP 5, loads/stores 7.
// Memory states stall on mem_r; a stall reaching MEM_WAIT_MAX cycles sets mem_err and halts.
module lc3_control_unit #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int STATE_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  lc3_control_unit_if.master   bus
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  // S_IDLE is encoded as zero so the debug port reads 0 out of reset.
  typedef enum logic [4:0] {
    S_IDLE = 5'd0,
    S_F1   = 5'd1,
    S_F2   = 5'd2,
    S_F3   = 5'd3,
    S_DEC  = 5'd4,
    S_OP   = 5'd5,
    S_BR   = 5'd6,
    S_JMP  = 5'd7,
    S_LD1  = 5'd8,
    S_LDR1 = 5'd9,
    S_RD   = 5'd10,
    S_LD3  = 5'd11,
    S_ST1  = 5'd12,
    S_STR1 = 5'd13,
    S_ST2  = 5'd14,
    S_WR   = 5'd15,
    S_HALT = 5'd16
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             in_wait;
  logic             timeout;
  logic             br_taken;
  logic [3:0]       opcode;
  logic             unused_ir;

  assign opcode    = bus.ir[15:12];
  assign unused_ir = ^bus.ir[8:0];
  assign br_taken  = (bus.ir[11] & bus.n) | (bus.ir[10] & bus.z) | (bus.ir[9] & bus.p);
  assign in_wait   = (state == S_F2) || (state == S_RD) || (state == S_WR);
  // A ready on the last allowed cycle still wins over the timeout.
  assign timeout   = in_wait && !bus.mem_r && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_wait && !bus.mem_r && !timeout) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (timeout) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_err = mem_err_q;
  assign bus.state_o = STATE_W'(state);

  always_comb begin
    state_nxt       = state;
    bus.ld_mar      = 1'b0;
    bus.ld_mdr      = 1'b0;
    bus.ld_ir       = 1'b0;
    bus.ld_pc       = 1'b0;
    bus.ld_reg      = 1'b0;
    bus.ld_cc       = 1'b0;
    bus.gate_pc     = 1'b0;
    bus.gate_mdr    = 1'b0;
    bus.gate_alu    = 1'b0;
    bus.gate_marmux = 1'b0;
    bus.pcmux       = 2'b00;
    bus.addr1mux    = 1'b0;
    bus.addr2mux    = 2'b00;
    bus.marmux      = 1'b0;
    bus.sr1mux      = 2'b00;
    bus.drmux       = 2'b00;
    bus.aluk        = 2'b00;
    bus.mio_en      = 1'b0;
    bus.r_w         = 1'b0;
    bus.halted      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.run) state_nxt = S_F1;
      end

      S_F1: begin
        bus.gate_pc = 1'b1;
        bus.ld_mar  = 1'b1;
        bus.ld_pc   = 1'b1;
        bus.pcmux   = 2'b00;
        state_nxt   = S_F2;
      end

      S_F2, S_RD: begin
        bus.mio_en = 1'b1;
        bus.r_w    = 1'b0;
        bus.ld_mdr = bus.mem_r;
        if (bus.mem_r) begin
          state_nxt = (state == S_F2) ? S_F3 : S_LD3;
        end else if (timeout) begin
          state_nxt = S_HALT;
        end
      end

      S_F3: begin
        bus.gate_mdr = 1'b1;
        bus.ld_ir    = 1'b1;
        state_nxt    = S_DEC;
      end

      S_DEC: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001: state_nxt = S_OP;
          4'b0000:                   state_nxt = S_BR;
          4'b1100:                   state_nxt = S_JMP;
          4'b0010:                   state_nxt = S_LD1;
          4'b0110:                   state_nxt = S_LDR1;
          4'b0011:                   state_nxt = S_ST1;
          4'b0111:                   state_nxt = S_STR1;
          default:                   state_nxt = S_HALT;
        endcase
      end

      S_OP: begin
        bus.sr1mux   = 2'b01;
        bus.gate_alu = 1'b1;
        bus.ld_reg   = 1'b1;
        bus.ld_cc    = 1'b1;
        bus.drmux    = 2'b00;
        case (opcode)
          4'b0101: bus.aluk = 2'b01;
          4'b1001: bus.aluk = 2'b10;
          default: bus.aluk = 2'b00;
        endcase
        state_nxt = S_F1;
      end

      S_BR: begin
        if (br_taken) begin
          bus.ld_pc    = 1'b1;
          bus.pcmux    = 2'b10;
          bus.addr1mux = 1'b0;
          bus.addr2mux = 2'b10;
        end
        state_nxt = S_F1;
      end

      S_JMP: begin
        bus.ld_pc    = 1'b1;
        bus.pcmux    = 2'b10;
        bus.addr1mux = 1'b1;
        bus.addr2mux = 2'b00;
        bus.sr1mux   = 2'b01;
        state_nxt    = S_F1;
      end

      // PC-relative MAR load (LD/ST) versus BaseR+offset6 (LDR/STR).
      S_LD1, S_ST1: begin
        bus.gate_marmux = 1'b1;
        bus.marmux      = 1'b1;
        bus.addr1mux    = 1'b0;
        bus.addr2mux    = 2'b10;
        bus.ld_mar      = 1'b1;
        state_nxt       = (state == S_LD1) ? S_RD : S_ST2;
      end

      S_LDR1, S_STR1: begin
        bus.gate_marmux = 1'b1;
        bus.marmux      = 1'b1;
        bus.addr1mux    = 1'b1;
        bus.addr2mux    = 2'b01;
        bus.sr1mux      = 2'b01;
        bus.ld_mar      = 1'b1;
        state_nxt       = (state == S_LDR1) ? S_RD : S_ST2;
      end

      S_LD3: begin
        bus.gate_mdr = 1'b1;
        bus.ld_reg   = 1'b1;
        bus.ld_cc    = 1'b1;
        bus.drmux    = 2'b00;
        state_nxt    = S_F1;
      end

      S_ST2: begin
        bus.sr1mux   = 2'b00;
        bus.aluk     = 2'b11;
        bus.gate_alu = 1'b1;
        bus.ld_mdr   = 1'b1;
        state_nxt    = S_WR;
      end

      S_WR: begin
        bus.mio_en = 1'b1;
        bus.r_w    = 1'b1;
        if (bus.mem_r) begin
          state_nxt = S_F1;
        end else if (timeout) begin
          state_nxt = S_HALT;
        end
      end

      S_HALT: begin
        bus.halted = 1'b1;
        state_nxt  = S_HALT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/lc3_control_unit.md
Name: lc3_control_unit

Overview:
- Moore-style LC-3 control sequencer. It issues every control word that the datapath, processing_unit, PC, MAR/MDR and bus gates consume.
- It is the initiator side of the processing_unit control interface: the source of ld_reg/aluk/sr1mux/drmux.
- It is also the memory-request initiator (mio_en/r_w with mem_r ready).
- It executes the subset needed for bubble sort: ADD, AND, NOT, BR, JMP, LD, ST, LDR, STR. Any other opcode halts.

Parameters:
- MEM_WAIT_MAX, 15: max cycles waiting for mem_r before memory-timeout halt.
- STATE_W, 5: width of debug state output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start; sampled in S_IDLE.
- ir  in  16  current instruction register contents.
- n, z, p  in  1 each  condition codes.
- mem_r  in  1  memory ready/done for current access.
- ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc  out  1 each  register load enables.
- gate_pc, gate_mdr, gate_alu, gate_marmux  out  1 each  bus drivers; at most one high per cycle.
- pcmux  out  2  00 PC+1, 01 bus, 10 address adder.
- addr1mux  out  1  0 PC, 1 SR1 (BaseR).
- addr2mux  out  2  00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0]).
- marmux  out  1  1 = address adder (only value used).
- sr1mux  out  2  00 IR[11:9], 01 IR[8:6], 10 R6.
- drmux  out  2  00 IR[11:9], 01 R7, 10 R6.
- aluk  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS_A.
- mio_en  out  1  memory access request.
- r_w  out  1  1 write, 0 read.
- halted  out  1  sticky; set in S_HALT.
- mem_err  out  1  sticky; set on memory timeout.
- state_o  out  STATE_W  current state encoding, debug only.

Behaviour:
- Reset (reset=0, async): state=S_IDLE, wait counter=0, halted=0, mem_err=0. All outputs are 0 while in reset and in S_IDLE.
- Outputs are a combinational decode of the registered state, plus ir/n/z/p in S_BR. Any signal not listed for a state is 0.
- S_IDLE: go to S_F1 when run=1.
- S_F1: gate_pc, ld_mar, ld_pc, pcmux=00. Next S_F2.
- S_F2: mio_en=1, r_w=0, ld_mdr=mem_r. Stay until mem_r=1, then go to S_F3.
- S_F3: gate_mdr, ld_ir. Next S_DEC.
- S_DEC: no outputs. Branch on ir[15:12]:
  - 0001 or 0101 or 1001 → S_OP
  - 0000 → S_BR
  - 1100 → S_JMP
  - 0010 → S_LD1
  - 0110 → S_LDR1
  - 0011 → S_ST1
  - 0111 → S_STR1
  - anything else → S_HALT
- S_OP: sr1mux=01, aluk = 00/01/10 for opcode 0001/0101/1001, gate_alu, ld_reg, ld_cc, drmux=00. Next S_F1.
- S_BR: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). If taken: ld_pc, pcmux=10, addr1mux=0, addr2mux=10. Next S_F1. ir[11:9]=000 is never taken.
- S_JMP: ld_pc, pcmux=10, addr1mux=1, addr2mux=00, sr1mux=01. Next S_F1.
- S_LD1: gate_marmux, marmux=1, addr1mux=0, addr2mux=10, ld_mar. Next S_RD.
- S_LDR1: same as S_LD1 but addr1mux=1, addr2mux=01, sr1mux=01. Next S_RD.
- S_RD: read wait, identical to S_F2. On mem_r go to S_LD3.
- S_LD3: gate_mdr, ld_reg, ld_cc, drmux=00. Next S_F1.
- S_ST1 / S_STR1: MAR loads as in LD1 / LDR1. Next S_ST2.
- S_ST2: sr1mux=00, aluk=11, gate_alu, ld_mdr. Next S_WR.
- S_WR: mio_en=1, r_w=1. Stay until mem_r=1, then go to S_F1.
- Wait counter:
  - Increments each cycle in S_F2/S_RD/S_WR while mem_r=0, and clears on leaving those states.
  - When the count reaches MEM_WAIT_MAX with mem_r still 0: set mem_err, go to S_HALT.
  - mem_r=1 in the same cycle the limit is reached counts as success.
- S_HALT: all control outputs 0, halted=1. Only reset leaves this state; run is ignored.
- Latency with mem_r=1 immediately:
  - fetch: 3 cycles, plus decode 1.
  - ADD: 5 cycles total.
  - LD/LDR: 7 cycles.
  - ST/STR: 7 cycles.
  - BR/JMP: 5 cycles.
- Invariant: at most one gate_* high in any cycle. ld_reg and ld_mdr are never both high.
- Reset asserted mid-access (e.g. during S_WR) drops mio_en immediately and returns to S_IDLE; no partial state is retained.

Test Plan:
- Reset/idle: reset=0 then 1, run=0 for 5 cycles → all outputs 0, state_o=S_IDLE. Pulse run → ld_mar=gate_pc=ld_pc=1 on the next cycle.
- ADD reg: ir=0x1642 (R3=R1+R2), mem_r=1 → S_OP asserts sr1mux=01, aluk=00, gate_alu, ld_reg, ld_cc, drmux=00, for exactly 1 cycle. Next cycle is S_F1.
- Immediate ADD and NOT: ir=0x1028 gives aluk=00 in S_OP. ir=0x927F gives aluk=10. Sequence length is 5 cycles from S_F1 to S_F1.
- BR: ir=0x0403 (BRz) with z=1 → ld_pc=1, pcmux=10, addr2mux=10. The same ir with z=0, n=1 → ld_pc=0.
- LDR/STR with 3-cycle memory delay:
  - ir=0x6A42: mem_r held 0 for 3 cycles in S_RD, then gate_mdr+ld_reg+ld_cc for 1 cycle.
  - ir=0x7A42: S_ST2 has aluk=11, sr1mux=00, ld_mdr. S_WR holds r_w=1, mio_en=1 until mem_r.
- Timeout/illegal:
  - mem_r stuck 0 in S_F2 for 15 cycles → mem_err=1, halted=1, outputs stay 0 with run toggling.
  - After reset, ir=0xF025 → S_HALT with mem_err=0.
